// File: rtl/stage_evaluator.sv
// Cascade stage sequencer: walks one detection window through all stages, fetching each
// stage threshold from the ROM and comparing it against the datapath's stage sum.
module stage_evaluator #(
    parameter int W_DATA   = 11,
    parameter int W_ADDR   = 5,
    parameter int N_STAGES = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              win_valid,
    output logic              win_ready,
    input  logic              flush,
    output logic              thr_en,
    output logic [W_ADDR-1:0] thr_addr,
    input  logic [W_DATA-1:0] thr_data,
    output logic              stage_req,
    output logic [W_ADDR-1:0] stage_idx,
    input  logic              sum_valid,
    output logic              sum_ready,
    input  logic [W_DATA-1:0] stage_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_detect,
    output logic [W_ADDR-1:0] res_stage
);

    localparam logic [W_ADDR-1:0] LAST = W_ADDR'(N_STAGES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, RESULT} state_t;

    state_t            state;
    state_t            next_state;
    logic [W_ADDR-1:0] stage;
    logic [W_DATA-1:0] thr_q;
    logic              pass;
    logic              last;
    logic              accept;
    logic              handshake;

    // Equality passes; both operands are two's complement.
    assign pass      = $signed(stage_sum) >= $signed(thr_q);
    assign last      = (stage == LAST);
    assign accept    = (state == IDLE) && win_valid && !flush;
    assign handshake = (state == WAIT) && sum_valid && !flush;

    // Outputs decode the state so an asynchronous reset clears them immediately.
    assign win_ready = (state == IDLE);
    assign thr_en    = (state == FETCH);
    assign stage_req = (state == FETCH);
    assign sum_ready = (state == WAIT);
    assign res_valid = (state == RESULT);
    assign thr_addr  = stage;
    assign stage_idx = stage;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (win_valid) next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = WAIT;
            WAIT:    if (sum_valid) next_state = (pass && !last) ? FETCH : RESULT;
            RESULT:  if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush blocks every handshake, so the window state below only moves on clean cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage      <= '0;
            thr_q      <= '0;
            res_detect <= 1'b0;
            res_stage  <= '0;
        end else begin
            if (accept) begin
                stage <= '0;
            end
            if (state == LOAD) begin
                thr_q <= thr_data;
            end
            if (handshake) begin
                if (!pass) begin
                    res_detect <= 1'b0;
                    res_stage  <= stage;
                end else if (last) begin
                    res_detect <= 1'b1;
                    res_stage  <= stage;
                end else begin
                    stage <= stage + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_evaluator.sv
// Self-checking bench for stage_evaluator: table vectors, random windows against a
// per-window cascade model, and hand sequences for flush and asynchronous reset.
module tb_stage_evaluator;

    localparam int W_DATA   = 11;
    localparam int W_ADDR   = 5;
    localparam int N_STAGES = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic              win_valid;
    logic              win_ready;
    logic              flush;
    logic              thr_en;
    logic [W_ADDR-1:0] thr_addr;
    logic [W_DATA-1:0] thr_data;
    logic              stage_req;
    logic [W_ADDR-1:0] stage_idx;
    logic              sum_valid;
    logic              sum_ready;
    logic [W_DATA-1:0] stage_sum;
    logic              res_valid;
    logic              res_ready;
    logic              res_detect;
    logic [W_ADDR-1:0] res_stage;

    stage_evaluator #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_STAGES(N_STAGES)) dut (
        .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(win_ready), .flush(flush),
        .thr_en(thr_en), .thr_addr(thr_addr), .thr_data(thr_data), .stage_req(stage_req),
        .stage_idx(stage_idx), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .stage_sum(stage_sum), .res_valid(res_valid), .res_ready(res_ready),
        .res_detect(res_detect), .res_stage(res_stage)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic signed [W_DATA-1:0] rom    [32];
    logic signed [W_DATA-1:0] sums   [32];
    int                       stalls [32];

    typedef struct {
        int   addr;
        int   idx;
        logic en;
        logic req;
        int   c;
    } fetch_t;
    fetch_t fetch_q[$];

    typedef struct {
        int thr_val;
        int sum_val;
        int rej_stage;
        int rej_sum;
        int stall_stage;
        int stall_len;
        int hold;
        int exp_det;
        int exp_stage;
        int exp_lat;
    } vec_t;
    vec_t vecs[8];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (thr_en) thr_data <= rom[thr_addr];
    end

    // Datapath stand-in: offers the sum after the programmed number of WAIT stall cycles.
    int dp_cnt = 0;
    always @(negedge clk) begin
        if (!rst || !sum_ready) begin
            sum_valid = 1'b0;
            dp_cnt    = 0;
        end else begin
            if (dp_cnt >= stalls[stage_idx]) begin
                sum_valid = 1'b1;
                stage_sum = sums[stage_idx];
            end
            dp_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && (thr_en || stage_req))
            fetch_q.push_back('{int'(thr_addr), int'(stage_idx), thr_en, stage_req, cyc});
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Cascade rule: stages run in order, the first sum below its threshold rejects.
    function automatic void model(output logic det, output int stg, output int lat,
                                  output int nf);
        det = 1'b1;
        stg = N_STAGES - 1;
        nf  = N_STAGES;
        lat = 1;
        for (int k = 0; k < N_STAGES; k++) begin
            lat += 3 + stalls[k];
            if (sums[k] < rom[k]) begin
                det = 1'b0;
                stg = k;
                nf  = k + 1;
                break;
            end
        end
    endfunction

    task automatic applyStimulus(input int hold, output int got_det, output int got_stage,
                                 output int got_lat);
        logic exp_det;
        int   exp_stage, exp_lat, exp_n, c0, n, bad, t;
        model(exp_det, exp_stage, exp_lat, exp_n);
        got_det   = -1;
        got_stage = -1;
        got_lat   = -1;
        @(negedge clk);
        checkOutput("win_ready_before_window", int'(win_ready), 1);
        fetch_q.delete();
        win_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        win_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            checks++;
            failures++;
            $display("[TB] FAIL res_valid_timeout: none after %0d cycles, expected one", n);
            return;
        end
        got_det   = int'(res_detect);
        got_stage = int'(res_stage);
        got_lat   = cyc - c0;
        checkOutput("model_latency", got_lat, exp_lat);
        checkOutput("model_detect", got_det, int'(exp_det));
        checkOutput("model_stage", got_stage, exp_stage);
        checkOutput("fetch_count", fetch_q.size(), exp_n);
        bad = -1;
        t   = c0 + 1;
        for (int k = 0; k < exp_n; k++) begin
            if (k >= fetch_q.size() || !fetch_q[k].en || !fetch_q[k].req ||
                fetch_q[k].addr != k || fetch_q[k].idx != k || fetch_q[k].c != t) begin
                bad = k;
                break;
            end
            t += 3 + stalls[k];
        end
        checkOutput("fetch_seq_first_bad_stage", bad, -1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_res_valid", int'(res_valid), 1);
            checkOutput("hold_res_detect", int'(res_detect), int'(exp_det));
            checkOutput("hold_res_stage", int'(res_stage), exp_stage);
            checkOutput("hold_win_ready", int'(win_ready), 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("post_result_win_ready", int'(win_ready), 1);
        checkOutput("post_result_res_valid", int'(res_valid), 0);
    endtask

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < 32; k++) begin
            rom[k]    = W_DATA'(v.thr_val);
            sums[k]   = W_DATA'(v.sum_val);
            stalls[k] = 0;
        end
        if (v.rej_stage >= 0) sums[v.rej_stage] = W_DATA'(v.rej_sum);
        if (v.stall_stage >= 0) stalls[v.stall_stage] = v.stall_len;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gd, gs, gl, n, th, sm;
        rst       = 1'b1;
        win_valid = 1'b0;
        flush     = 1'b0;
        res_ready = 1'b0;
        thr_data  = '0;
        stage_sum = '0;
        sum_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rom[k] = '0; sums[k] = '0; stalls[k] = 0;
        end
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_thr_en", int'(thr_en), 0);
        checkOutput("rst_thr_addr", int'(thr_addr), 0);
        checkOutput("rst_stage_req", int'(stage_req), 0);
        checkOutput("rst_stage_idx", int'(stage_idx), 0);
        checkOutput("rst_sum_ready", int'(sum_ready), 0);
        checkOutput("rst_res_valid", int'(res_valid), 0);
        checkOutput("rst_res_detect", int'(res_detect), 0);
        checkOutput("rst_res_stage", int'(res_stage), 0);
        checkOutput("rst_win_ready", int'(win_ready), 1);
        @(negedge clk);
        rst = 1'b1;

        // thr, sum, rej_stage, rej_sum, stall_stage, stall_len, hold, detect, stage, latency
        vecs[0] = '{-514, -514,  1, -600, -1, 0, 0, 0,  1,  7};
        vecs[1] = '{-514, -514,  0, -515, -1, 0, 5, 0,  0,  4};
        vecs[2] = '{   0,    0, -1,    0, -1, 0, 0, 1, 24, 76};
        vecs[3] = '{-396, -396,  7, -397,  3, 4, 0, 0,  7, 29};
        vecs[4] = '{1023, 1023, -1,    0, -1, 0, 2, 1, 24, 76};
        vecs[5] = '{-1023, -1023, 24, -1024, -1, 0, 1, 0, 24, 76};
        vecs[6] = '{   5,    5, 12,    4,  0, 2, 0, 0, 12, 42};
        vecs[7] = '{ 100,  101,  3,   99,  3, 1, 0, 0,  3, 14};
        for (int i = 0; i < 8; i++) begin
            load_vec(vecs[i]);
            applyStimulus(vecs[i].hold, gd, gs, gl);
            checkOutput($sformatf("vec%0d_detect", i), gd, vecs[i].exp_det);
            checkOutput($sformatf("vec%0d_stage", i), gs, vecs[i].exp_stage);
            checkOutput($sformatf("vec%0d_latency", i), gl, vecs[i].exp_lat);
        end

        // Flush in WAIT of stage 5 while the sum is being offered.
        load_vec(vecs[2]);
        @(negedge clk);
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        n = 0;
        while (!(sum_ready && stage_idx == 5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("flush_reached_stage5_wait", int'(sum_ready && stage_idx == 5), 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_win_ready", int'(win_ready), 1);
        checkOutput("flush_res_valid", int'(res_valid), 0);
        checkOutput("flush_thr_en", int'(thr_en), 0);
        checkOutput("flush_stage_req", int'(stage_req), 0);
        checkOutput("flush_sum_ready", int'(sum_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("flush_no_result", int'(res_valid), 0);
        end
        flush     = 1'b1;
        win_valid = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        win_valid = 1'b0;
        checkOutput("flush_idle_win_ready", int'(win_ready), 1);
        checkOutput("flush_idle_no_fetch", int'(thr_en), 0);
        applyStimulus(0, gd, gs, gl);
        checkOutput("after_flush_detect", gd, 1);

        // Asynchronous reset in LOAD of stage 2.
        load_vec(vecs[2]);
        @(negedge clk);
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        n = 0;
        while (!(thr_en && thr_addr == 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("pre_reset_stage_idx", int'(stage_idx), 2);
        #1 rst = 1'b0;
        #1;
        checkOutput("async_rst_thr_en", int'(thr_en), 0);
        checkOutput("async_rst_stage_req", int'(stage_req), 0);
        checkOutput("async_rst_res_valid", int'(res_valid), 0);
        checkOutput("async_rst_stage_idx", int'(stage_idx), 0);
        checkOutput("async_rst_win_ready", int'(win_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        load_vec(vecs[7]);
        applyStimulus(0, gd, gs, gl);
        checkOutput("after_reset_stage", gs, 3);

        // Random windows: mostly passing sums, occasional rejections and stalls.
        for (int w = 0; w < 40; w++) begin
            for (int k = 0; k < 32; k++) begin
                th = int'($urandom_range(0, 1600)) - 800;
                if ($urandom_range(0, 29) == 0)
                    sm = th - 1 - int'($urandom_range(0, 100));
                else if ($urandom_range(0, 4) == 0)
                    sm = th;
                else
                    sm = th + int'($urandom_range(0, 200));
                rom[k]    = W_DATA'(th);
                sums[k]   = W_DATA'(sm);
                stalls[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            applyStimulus(int'($urandom_range(0, 2)), gd, gs, gl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
